// File: rtl/sop_lut_engine.sv
// rtl/sop_lut_engine.sv - programmable N-input SOP truth-table engine with stream evaluation
// Optional SOP_ONES_COUNT_EN adds a registered minterm count output (ones_cnt).
module sop_lut_engine #(
    parameter int                N           = 4,
    parameter logic [2**N-1:0]   RESET_TABLE = 16'h831B
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         f,
    input  logic         prog_start,
    input  logic         prog_valid,
    input  logic         prog_bit,
    output logic         prog_busy,
    output logic         tbl_updated
`ifdef SOP_ONES_COUNT_EN
    ,
    output logic [N:0]   ones_cnt
`endif
);

    localparam int         T    = 2**N;
    localparam logic [N:0] LAST = (N+1)'(T - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t         state, state_nxt;
    logic [N:0]     cnt, cnt_nxt;
    logic [T-1:0]   shadow, shadow_nxt;
    logic [T-1:0]   active_tbl;
    logic           commit;

    assign in_ready  = !out_valid || out_ready;
    assign prog_busy = (state == LOAD);

    // A restart always wins; a simultaneous bit becomes bit 0 of the new load.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        commit     = 1'b0;
        if (prog_start) begin
            state_nxt  = LOAD;
            cnt_nxt    = '0;
            shadow_nxt = '0;
            if (prog_valid) begin
                shadow_nxt[0] = prog_bit;
                cnt_nxt       = (N+1)'(1);
            end
        end else if (state == LOAD && prog_valid) begin
            shadow_nxt[cnt[N-1:0]] = prog_bit;
            if (cnt == LAST) begin
                commit    = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + (N+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            active_tbl  <= RESET_TABLE;
            tbl_updated <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shadow      <= shadow_nxt;
            tbl_updated <= commit;
            if (commit)
                active_tbl <= shadow_nxt;
        end
    end

    // Lookup reads the pre-commit table, so a request in the commit cycle sees the old function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            f         <= active_tbl[i];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SOP_ONES_COUNT_EN
    function automatic logic [N:0] popcount(input logic [T-1:0] v);
        logic [N:0] c;
        c = '0;
        for (int k = 0; k < T; k++)
            c = c + (N+1)'(v[k]);
        return c;
    endfunction

    localparam logic [N:0] ONES_RST = popcount(RESET_TABLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ones_cnt <= ONES_RST;
        else if (commit)
            ones_cnt <= popcount(shadow_nxt);
    end
`endif

endmodule

// File: tb/tb_sop_lut_engine.sv
// tb/tb_sop_lut_engine.sv - directed plus randomized check of sop_lut_engine against a table model
module tb_sop_lut_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, f;
    logic [3:0] i;
    logic       prog_start, prog_valid, prog_bit, prog_busy, tbl_updated;
`ifdef SOP_ONES_COUNT_EN
    logic [4:0] ones_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_tbl;
    logic        m_ov, m_f, m_busy, m_upd;
    bit          m_bits[$];

    always #5 clk = ~clk;

    sop_lut_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .f(f),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_bit(prog_bit),
        .prog_busy(prog_busy), .tbl_updated(tbl_updated)
`ifdef SOP_ONES_COUNT_EN
        , .ones_cnt(ones_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tbl  = 16'h831B;
        m_ov   = 1'b0;
        m_f    = 1'b0;
        m_busy = 1'b0;
        m_upd  = 1'b0;
        m_bits.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".f"}, 32'(f), 32'(m_f));
        chk({tag, ".prog_busy"}, 32'(prog_busy), 32'(m_busy));
        chk({tag, ".tbl_updated"}, 32'(tbl_updated), 32'(m_upd));
`ifdef SOP_ONES_COUNT_EN
        chk({tag, ".ones_cnt"}, 32'(ones_cnt), 32'($countones(m_tbl)));
`endif
    endtask

    // One clock: check in_ready, advance the model by the spec rules, then check registered outputs.
    task automatic tick(input string tag);
        logic rdy;
        #1;
        rdy = !m_ov || out_ready;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        if (in_valid && rdy) begin
            m_f  = m_tbl[i];
            m_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        m_upd = 1'b0;
        if (prog_start) begin
            m_busy = 1'b1;
            m_bits.delete();
            if (prog_valid) m_bits.push_back(prog_bit);
        end else if (m_busy && prog_valid) begin
            m_bits.push_back(prog_bit);
            if (m_bits.size() == 16) begin
                for (int k = 0; k < 16; k++) m_tbl[k] = m_bits[k];
                m_bits.delete();
                m_busy = 1'b0;
                m_upd  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b1; i = '0;
        prog_start = 1'b0; prog_valid = 1'b0; prog_bit = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        logic [3:0]  exp1 [16];

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // 1: stream all minterms of the reset table at full rate
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; i = 4'(k);
            tick("stream");
            chk("stream.lit", 32'(f), 32'(((16'h831B) >> k) & 1));
        end
        in_valid = 1'b0;
        tick("stream_drain");

        // 2: backpressure holds the result
        in_valid = 1'b1; i = 4'd3; out_ready = 1'b1;
        tick("bp_accept");
        i = 4'd2; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("bp_hold");
            chk("bp_hold.f_lit", 32'(f), 32'd1);
        end
        out_ready = 1'b1;
        tick("bp_release");
        chk("bp_release.f_lit", 32'(f), 32'd0);
        in_valid = 1'b0;
        tick("bp_drain");

        // 3+4: load 16'h8000, evaluate i=0 in the commit cycle and the cycle after
        prog_start = 1'b1;
        tick("prog_start");
        prog_start = 1'b0;
        pat = 16'h8000;
        for (int k = 0; k < 16; k++) begin
            prog_valid = 1'b1; prog_bit = pat[k];
            if (k == 15) begin in_valid = 1'b1; i = 4'd0; end
            tick("prog_bit");
        end
        prog_valid = 1'b0;
        chk("commit.old_tbl", 32'(f), 32'd1);
        chk("commit.pulse", 32'(tbl_updated), 32'd1);
        tick("after_commit");
        chk("after_commit.new_tbl", 32'(f), 32'd0);
        i = 4'd15;
        tick("new_i15");
        chk("new_i15.lit", 32'(f), 32'd1);
        in_valid = 1'b0;
        tick("prog_drain");

        // 5: restart mid-load with a simultaneous bit
        prog_start = 1'b1;
        tick("rs_start");
        prog_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            prog_valid = 1'b1; prog_bit = 1'($urandom);
            tick("rs_partial");
        end
        prog_start = 1'b1; prog_valid = 1'b1; prog_bit = 1'b1;
        tick("rs_restart");
        prog_start = 1'b0; prog_bit = 1'b0;
        for (int k = 0; k < 15; k++) tick("rs_bits");
        prog_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; i = 4'(k);
            tick("rs_eval");
            chk("rs_eval.lit", 32'(f), 32'(k == 0));
        end
        in_valid = 1'b0;
        tick("rs_drain");

        // 6: asynchronous reset mid-load with a result pending
        prog_start = 1'b1;
        tick("rl_start");
        prog_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            prog_valid = 1'b1; prog_bit = 1'b1;
            in_valid = (k == 7); i = 4'd1; out_ready = 1'b0;
            tick("rl_bits");
        end
        prog_valid = 1'b0; in_valid = 1'b0;
        chk("rl_pending", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rl_async.prog_busy", 32'(prog_busy), 32'd0);
        chk("rl_async.out_valid", 32'(out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; i = 4'd9;
        tick("rl_i9");
        chk("rl_i9.lit", 32'(f), 32'd1);
        in_valid = 1'b0;
        tick("rl_drain");

        // Randomized mix of evaluation, backpressure and programming
        exp1[0] = 4'd0;
        for (int n = 0; n < 1500; n++) begin
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(3) != 0);
            i          = 4'($urandom_range(15));
            prog_start = ($urandom_range(47) == 0);
            prog_valid = ($urandom_range(3) != 0);
            prog_bit   = 1'($urandom);
            tick("rand");
        end
        idle_inputs();
        tick("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sop_lut_engine.md
Name: sop_lut_engine

Overview:
- Parametrised, programmable successor to the fixed 4-input SOP function block.
- Evaluates an N-input boolean function held as a 2^N-bit minterm truth table; bit k = 1 means minterm k is in the SOP.
- Table reloads at run time over a serial programming port and commits atomically.
- Evaluation is a registered valid/ready stream stage, so the block drops into pipelined datapaths.

Parameters:
N, 4, number of function inputs; legal range 1..8.
RESET_TABLE, 16'h831B, truth table loaded at reset, width 2^N; the default is SOP(0,1,3,4,8,9,15).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  evaluation request valid
in_ready  output  1  block can accept a request
i  input  N  minterm index / function inputs
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
f  output  1  function value for the accepted i
prog_start  input  1  one-cycle pulse; begins a new table load
prog_valid  input  1  prog_bit is valid this cycle
prog_bit  input  1  serial table bit, minterm 0 first
prog_busy  output  1  load in progress
tbl_updated  output  1  one-cycle pulse when the new table commits

Behaviour:
- Reset (async assert, sync release):
  - active table = RESET_TABLE; shadow = 0; bit counter = 0; FSM = IDLE.
  - out_valid = 0; f = 0; prog_busy = 0; tbl_updated = 0.
- Evaluation:
  - in_ready = !out_valid || out_ready (combinational).
  - Handshake occurs when in_valid && in_ready.
  - On handshake: f <= active_table[i], out_valid <= 1 at the next edge. Latency is 1 cycle.
  - When out_valid && out_ready with no new handshake, out_valid <= 0.
  - f holds while out_valid && !out_ready (backpressure).
  - Full throughput of 1 result/cycle when out_ready is held high.
- Programming FSM, states IDLE and LOAD:
  - IDLE: prog_valid is ignored. prog_start -> LOAD with counter = 0.
  - LOAD: prog_busy = 1. Each prog_valid cycle writes shadow[counter] = prog_bit and increments the counter.
  - The accepted bit with counter = 2^N-1 commits: active table <= shadow including that bit, FSM -> IDLE, counter -> 0, tbl_updated = 1 for exactly the next cycle.
  - prog_start in LOAD discards the partial load and restarts at counter 0. The active table is untouched.
  - prog_start and prog_valid in the same cycle: the restart applies and prog_bit is taken as bit 0 (counter -> 1).
- Simultaneous events:
  - An evaluation handshake in the commit cycle uses the old table. The first request using the new table is the one accepted in the cycle tbl_updated is high.
  - Evaluation is never stalled by programming; in_ready does not depend on prog_busy.
- Reset mid-load: the partial load is lost and the table returns to RESET_TABLE.
- Reset with out_valid high: the result is dropped.
- Widths:
  - Counter is N+1 bits wide, so 2^N is representable for N=8.
  - i is used directly as the table index. No out-of-range indices exist.

Optional Feature:
- Macro: SOP_ONES_COUNT_EN.
- Defined:
  - Adds output port ones_cnt, width N+1 = number of 1 bits in the active table (minterm count).
  - ones_cnt is registered and updates in the cycle after a commit, i.e. coincident with tbl_updated.
  - Reset value = popcount(RESET_TABLE), which is 7 at default.
- Undefined: the port and popcount logic are absent; all other behaviour is identical.

Test Plan:
1. Reset defaults, N=4: after rst_n release, stream i=0..15 with out_ready=1 -> f = 1,1,0,1,1,0,0,0,1,1,0,0,0,0,0,1, each appearing 1 cycle after acceptance, no bubbles.
2. Backpressure: accept i=3, hold out_ready=0 for 3 cycles while in_valid=1 with i=2 -> in_ready=0, f stays 1, out_valid stays 1. Then out_ready=1 -> next result f=0 for i=2.
3. Reprogram: prog_start, then 16 bits of 16'h8000 LSB first -> tbl_updated pulses once after the 16th bit, prog_busy falls. Afterwards i=15 -> 1 and i=0 -> 0. With SOP_ONES_COUNT_EN, ones_cnt goes 7 -> 1.
4. Commit collision: evaluate i=0 in the commit cycle of item 3 -> f=1 (old table). i=0 in the next cycle -> f=0.
5. Restart: prog_start, 5 bits, prog_start+prog_valid(bit=1), then 15 bits of 0 -> table = 16'h0001, exactly one tbl_updated pulse.
6. Reset mid-load: after 8 bits, pulse rst_n low asynchronously between edges -> prog_busy=0, out_valid=0 immediately. Afterwards i=9 -> f=1 (RESET_TABLE restored).
